hex_scan_ctrl: RTL
==================

# hex_scan_ctrl

Time-multiplexed scan controller for the 8-digit hex display behind `gpio_out`. Holds the 32-bit display value, steps through its eight nibbles at a programmable rate, and presents one digit at a time (one-hot select, nibble, blank flag) to a single shared hexdriver. New values from the CPU are buffered and applied only at a frame boundary, so a scan never mixes old and new digits.

## Interface
- `DIV`, default 4: clock cycles per digit; legal range ≥1. Counter width is max(1, $clog2(DIV)).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets).
- `wr_en`  in  1  load request; `wr_data` is sampled on the same rising edge.
- `wr_data`  in  32  new display value; nibble i feeds digit i (digit 0 = bits 3:0).
- `blank_lz`  in  1  leading-zero blanking enable; level, sampled continuously.
- `wr_ready`  out  1  1 = no update pending.
- `dig_sel`  out  8  one-hot active-high digit select; bit i = digit i.
- `dig_nib`  out  4  nibble of the selected digit, to the shared hexdriver.
- `dig_blank`  out  1  1 = selected digit must be dark.
- `frame_done`  out  1  one-cycle pulse at the start of each new frame.
- `shown`  out  32  value currently being scanned.

## Operation
- State: prescaler `cnt` (0..DIV-1), digit index `idx` (0..7), `shown`, `pend_data`, `pending`, `frame_done` register.
- Tick: `cnt`==DIV-1. On a tick, `cnt`←0 and `idx`←`idx`+1 (7 wraps to 0). Otherwise `cnt`←`cnt`+1. With DIV=1, every cycle is a tick.
- Wrap tick: tick with `idx`==7. This is the only edge on which `shown` changes.
- Write capture: `wr_en`=1 on a non-wrap edge sets `pend_data`←`wr_data` and `pending`←1. A write while pending overwrites `pend_data` (last write wins); writes are never refused.
- At a wrap tick:
  - If `wr_en`=1 on that edge, `shown`←`wr_data` and `pending`←0. The direct write has priority over `pend_data`.
  - Else if `pending`, `shown`←`pend_data` and `pending`←0.
  - Else `shown` is unchanged.
- `wr_ready` = ~`pending`.
- Decode is combinational from registers:
  - `dig_sel` = 1<<`idx`.
  - `dig_nib` = `shown`[4*idx+3:4*idx].
- Blanking: `dig_blank`=1 iff `blank_lz`=1, `idx`>0, and `shown`[31:4*idx]==0.
  - Digit 0 is never blanked, so a value of 0 displays as a single "0".
  - When blanked, `dig_nib` still carries the true nibble and `dig_sel` stays asserted.
- Reset (`rst`=0, asynchronous):
  - `cnt`=0, `idx`=0, `shown`=0, `pend_data`=0, `pending`=0, `frame_done`=0.
  - Outputs therefore read: `dig_sel`=8'h01, `dig_nib`=0, `dig_blank`=0, `wr_ready`=1.
  - Any pending value is discarded.

## Timing
- Each digit is held exactly DIV cycles. One frame = 8·DIV cycles.
- `frame_done` is registered. It is 1 for exactly the one cycle after each wrap tick, coincident with `idx`=0 and the updated `shown`. It is 0 in every other cycle, including the cycle after reset release.
- Write-to-display latency:
  - 1 cycle if `wr_en` lands on the wrap edge.
  - Otherwise ≤8·DIV cycles; the value appears on the edge of the next wrap tick.
- `wr_ready` falls in the cycle after a non-wrap `wr_en`. It rises in the cycle after the wrap tick that consumes the pending value.
- After `rst` deasserts, the first tick occurs on the DIV-th rising edge. The first `frame_done` is asserted 8·DIV cycles after release.
- `blank_lz` changes take effect combinationally on `dig_blank` in the same cycle.

## Test plan
- Reset/free-run (DIV=4): hold `rst`=0 → `dig_sel`=01, `shown`=0, `wr_ready`=1, `frame_done`=0. After release, `dig_sel` walks 01,02,…,80 every 4 cycles, and `frame_done` pulses every 32 cycles.
- Mid-frame write of 0x8765_4321 at `idx`=3 → `wr_ready`=0 next cycle; `shown` stays 0 until the wrap. The following frame shows `dig_nib` = 1,2,3,4,5,6,7,8 for `idx` 0..7, with `frame_done` in the first cycle of that frame.
- Two writes in one frame (0x1111_1111, then 0x0000_00AB) → after the wrap, `shown`=0x0000_00AB and 0x11111111 is never displayed.
- Write of 0x0002_6789 on the wrap edge → `shown`=0x0002_6789 one cycle later, and `wr_ready` stays 1 throughout.
- `blank_lz`=1 with `shown`=0x0002_6789 → `dig_blank`=0 for `idx` 0–4 and 1 for `idx` 5–7. With `shown`=0, only `idx` 0 is unblanked. With `blank_lz`=0, no digit is ever blanked.
- `rst` pulsed low mid-frame with a write pending → all outputs return to reset values immediately (asynchronously). After release, the pending value never appears: `shown`=0 through the first wrap.

Source files
------------

// File: rtl/hex_scan_ctrl_if.sv
// Bus bundle between the CPU-side writer and the hex scan controller.
// The master side loads display values and sets blanking; the slave side
// (the controller) returns the handshake and the per-digit scan outputs.
interface hex_scan_ctrl_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        blank_lz;
  logic        wr_ready;
  logic [7:0]  dig_sel;
  logic [3:0]  dig_nib;
  logic        dig_blank;
  logic        frame_done;
  logic [31:0] shown;

  modport master (
    output wr_en, wr_data, blank_lz,
    input  wr_ready, dig_sel, dig_nib, dig_blank, frame_done, shown
  );

  modport slave (
    input  wr_en, wr_data, blank_lz,
    output wr_ready, dig_sel, dig_nib, dig_blank, frame_done, shown
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit hex display.
// Steps through the eight nibbles of the displayed value, DIV cycles per
// digit, and swaps in new values only at the frame boundary so one scan
// never mixes old and new digits.
module hex_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  hex_scan_ctrl_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [31:0]   shown_r;
  logic [31:0]   pend_data_r;
  logic          pending_r;
  logic          frame_done_r;

  logic          tick_s;
  logic          wrap_s;
  logic [31:0]   upper_s;
  logic [7:0]    dig_sel_s;
  logic [3:0]    dig_nib_s;
  logic          dig_blank_s;

  // Tick and frame-wrap detection from the prescaler and digit index.
  always_comb begin
    tick_s = (cnt_r == CNT_MAX);
    wrap_s = tick_s && (idx_r == 3'd7);
  end

  // Prescaler, digit index and frame-done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= '0;
      idx_r        <= 3'd0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (tick_s) begin
        cnt_r <= '0;
        idx_r <= idx_r + 3'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
        idx_r <= idx_r;
      end
    end
  end

  // Update buffering: direct writes on the wrap edge win over the pending
  // value; any other write just refreshes the buffer (last write wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown_r     <= 32'd0;
      pend_data_r <= 32'd0;
      pending_r   <= 1'b0;
    end else if (wrap_s) begin
      if (bus.wr_en) begin
        shown_r   <= bus.wr_data;
        pending_r <= 1'b0;
      end else if (pending_r) begin
        shown_r   <= pend_data_r;
        pending_r <= 1'b0;
      end else begin
        shown_r   <= shown_r;
        pending_r <= pending_r;
      end
    end else if (bus.wr_en) begin
      pend_data_r <= bus.wr_data;
      pending_r   <= 1'b1;
    end else begin
      pend_data_r <= pend_data_r;
      pending_r   <= pending_r;
    end
  end

  // Digit decode; blanking keeps the true nibble and select, only flags dark.
  always_comb begin
    upper_s     = shown_r >> {idx_r, 2'b00};
    dig_sel_s   = 8'd1 << idx_r;
    dig_nib_s   = upper_s[3:0];
    dig_blank_s = 1'b0;
    if (bus.blank_lz && (idx_r != 3'd0) && (upper_s == 32'd0)) begin
      dig_blank_s = 1'b1;
    end else begin
      dig_blank_s = 1'b0;
    end
  end

  assign bus.wr_ready   = ~pending_r;
  assign bus.dig_sel    = dig_sel_s;
  assign bus.dig_nib    = dig_nib_s;
  assign bus.dig_blank  = dig_blank_s;
  assign bus.frame_done = frame_done_r;
  assign bus.shown      = shown_r;

endmodule
